// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } sub_state_t;

  // Subtraction is a + ~b + 1, so the carry chain starts at one.
  localparam logic CARRY_SEED = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the single arithmetic slice of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.
// Handshake: start is sampled only in IDLE; done pulses one cycle with diff/borrow_out valid.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);

  sub_state_t       state;
  sub_state_t       next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 sums produced so far; the final sum completes the word.
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             b_inv;
  logic             s;
  logic             c_next;

  assign b_inv    = ~b_sr[0];
  assign res_next = {s, res_sr};

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_inv),
    .c     (carry),
    .sum   (s),
    .carry (c_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = start ? SHIFT : IDLE;
      SHIFT:   next_state = (cnt == '0) ? DONE : SHIFT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            carry  <= CARRY_SEED;
            cnt    <= CW'(WIDTH - 1);
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next[WIDTH-1:1];
          carry  <= c_next;
          if (cnt == '0) begin
            diff       <= res_next;
            borrow_out <= ~c_next;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 scenarios plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       borrow4;

  int n_checks;
  int n_pass;

  logic [8:0] exp_q[$];

  serial_subtractor #(.WIDTH(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .a          (a4),
    .b          (b4),
    .busy       (busy4),
    .done       (done4),
    .diff       (diff4),
    .borrow_out (borrow4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation; glitch_cyc>0 re-pulses start with other operands mid-SHIFT.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] exp_diff, input logic exp_borrow, input int glitch_cyc);
    int         busy_cnt;
    int         done_cnt;
    int         first_done;
    logic       both;
    logic [8:0] exp;
    busy_cnt   = 0;
    done_cnt   = 0;
    first_done = 0;
    both       = 1'b0;
    exp_q.push_back({exp_borrow, exp_diff});
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = $urandom_range(0, 255);
    b     = $urandom_range(0, 255);
    if (busy) busy_cnt++;
    for (int k = 1; k <= 12; k++) begin
      if (k == glitch_cyc) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
      end
      tick();
      start = 1'b0;
      if (busy) busy_cnt++;
      if (busy && done) both = 1'b1;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check({tag, "_diff"}, diff, exp[7:0]);
          check({tag, "_borrow"}, borrow_out, exp[8]);
        end
      end
    end
    check({tag, "_latency"}, first_done, 8);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_busy_and_done"}, both, 1'b0);
    check({tag, "_diff_held"}, diff, exp_diff);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    start4   = 1'b0;
    a4       = '0;
    b4       = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_borrow", borrow_out, 1'b0);

    op8("t1_5a_3c", 8'h5A, 8'h3C, 8'h1E, 1'b0, 0);
    op8("t2_3c_5a", 8'h3C, 8'h5A, 8'hE2, 1'b1, 0);
    op8("t2_00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 0);
    op8("t3_ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 0);
    op8("t3_80_00", 8'h80, 8'h00, 8'h80, 1'b0, 0);
    op8("t4_ignore", 8'h10, 8'h01, 8'h0F, 1'b0, 3);

    // Reset in the middle of SHIFT
    begin
      int late_done;
      late_done = 0;
      a     = 8'h33;
      b     = 8'h11;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("t5_busy_before_rst", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_busy_in_rst", busy, 1'b0);
      check("t5_diff_in_rst", diff, 8'h00);
      check("t5_borrow_in_rst", borrow_out, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (done || busy) late_done++;
      end
      check("t5_no_done_after_abort", late_done, 0);
      op8("t5_07_09", 8'h07, 8'h09, 8'hFE, 1'b1, 0);
    end

    // start held high: accepts every WIDTH+2 cycles, operands sampled only then
    begin
      int n_done;
      n_done = 0;
      start  = 1'b1;
      for (int k = 0; k < 30; k++) begin
        a = 8'(3 * k + 1);
        b = 8'(k);
        tick();
        if (done) begin
          check("t6_done_cycle", k, 8 + 10 * n_done);
          check("t6_diff", diff, 8'(20 * n_done + 1));
          check("t6_borrow", borrow_out, 1'b0);
          check("t6_busy_with_done", busy, 1'b0);
          n_done++;
        end
        if (k == 15) check("t6_diff_holds", diff, 8'h01);
      end
      start = 1'b0;
      repeat (12) tick();
      check("t6_done_total", n_done, 3);
    end

    // Exhaustive WIDTH=4 sweep against an a-b model
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        int   wait_cyc;
        logic [4:0] exp4;
        exp4     = {(i < j) ? 1'b1 : 1'b0, 4'(i - j)};
        a4       = 4'(i);
        b4       = 4'(j);
        start4   = 1'b1;
        tick();
        start4   = 1'b0;
        wait_cyc = 0;
        while (!done4 && wait_cyc < 10) begin
          tick();
          wait_cyc++;
        end
        if (!done4) begin
          check("w4_timeout", wait_cyc, 4);
        end else begin
          check($sformatf("w4_%0d_%0d", i, j), {borrow4, diff4}, exp4);
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
